// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the two-master data-memory arbiter.
package dmem_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// master that was not granted last.
module rr_pick2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr,
   output logic       winner,
   output logic       any
);

   // Winner select; rr names the last-granted master
   always_comb begin
      any    = |req;
      winner = M0;
      if (req == 2'b11) begin
         winner = ~rr;
      end else if (req[1]) begin
         winner = M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: two masters share one single-port memory, one word
// per cycle, with round-robin fairness and bounded locked bursts.
//
// state | meaning
// IDLE  | no grant this cycle, memory outputs parked at 0
// BUSY  | owner holds the memory this cycle (one word transfer)
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int AW        = 10,
   parameter int DW        = 32,
   parameter int BURST_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_rvalid,
   output logic          m1_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_cs,
   output logic          mem_w,
   output logic          mem_r,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   // Last burst index; BURST_MAX is limited to 1..16 so this fits cnt.
   localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          rr_q, rr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    rvalid_q, rvalid_d;

   logic          busy;
   logic          own_req;
   logic          own_we;
   logic          own_lock;
   logic          keep;
   logic          pick_winner;
   logic          pick_any;

   rr_pick2 u_pick (
      .req    ({m1_req, m0_req}),
      .rr     (rr_q),
      .winner (pick_winner),
      .any    (pick_any)
   );

   // Owner view, grants and memory drive; everything parks at 0 when idle
   always_comb begin
      busy      = (state_q == ST_BUSY);
      own_req   = (owner_q == M1) ? m1_req  : m0_req;
      own_we    = (owner_q == M1) ? m1_we   : m0_we;
      own_lock  = (owner_q == M1) ? m1_lock : m0_lock;
      m0_gnt    = busy && (owner_q == M0);
      m1_gnt    = busy && (owner_q == M1);
      mem_cs    = busy;
      mem_w     = busy && own_we;
      mem_r     = busy && !own_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (busy) begin
         mem_addr  = (owner_q == M1) ? m1_addr  : m0_addr;
         mem_wdata = (owner_q == M1) ? m1_wdata : m0_wdata;
      end
   end

   // Next state: continue a locked burst, else re-arbitrate, else go idle
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      rvalid_d = '0;
      keep     = busy && own_req && own_lock && (cnt_q < CNT_LAST);

      if (keep) begin
         cnt_d = cnt_q + 4'd1;
      end else if (pick_any) begin
         state_d = ST_BUSY;
         owner_d = pick_winner;
         rr_d    = pick_winner;
         cnt_d   = '0;
      end else begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end

      // A read granted this cycle returns its word on the next one
      if (busy && !own_we) begin
         rdata_d           = mem_rdata;
         rvalid_d[owner_q] = 1'b1;
      end
   end

   // State registers; rr resets to M1 so m0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         owner_q  <= M0;
         rr_q     <= M1;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata     = rdata_q;
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: queue-driven masters, an abstract arbitration
// model compared every cycle, and literal pins on the directed scenarios.
module tb_dmem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BM = 4;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          lock;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] rdata;
   logic mem_cs, mem_w, mem_r;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem [0:1023];
   bit mem_init = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   txn_t q0[$];
   txn_t q1[$];

   dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .rdata(rdata), .mem_cs(mem_cs), .mem_w(mem_w), .mem_r(mem_r),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_addr];

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic req_of(int m);
      return (m == 1) ? m1_req : m0_req;
   endfunction
   function automatic logic we_of(int m);
      return (m == 1) ? m1_we : m0_we;
   endfunction
   function automatic logic lock_of(int m);
      return (m == 1) ? m1_lock : m0_lock;
   endfunction
   function automatic logic [AW-1:0] addr_of(int m);
      return (m == 1) ? m1_addr : m0_addr;
   endfunction
   function automatic logic [DW-1:0] wdata_of(int m);
      return (m == 1) ? m1_wdata : m0_wdata;
   endfunction

   // Model: holder is who owns the memory this cycle (-1 none), run is how
   // many extra cycles the current holder has kept it, last is the last
   // master picked by arbitration.
   int holder, run, last, pick;
   logic [1:0] e_rv;
   logic [DW-1:0] e_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
            mem[5] = 32'hDEAD_BEEF;
            mem_init = 1'b1;
         end
         holder = -1; run = 0; last = 1; e_rv = 2'b00; e_rdata = '0;
      end else begin
         e_rv = 2'b00;
         if (holder >= 0) begin
            if (we_of(holder)) mem[addr_of(holder)] = wdata_of(holder);
            else begin
               e_rdata = mem[addr_of(holder)];
               e_rv[holder] = 1'b1;
            end
         end
         if (holder >= 0 && req_of(holder) && lock_of(holder) && run < BM - 1) begin
            run = run + 1;
         end else if (m0_req || m1_req) begin
            if (m0_req && m1_req) pick = 1 - last;
            else pick = m1_req ? 1 : 0;
            holder = pick; last = pick; run = 0;
         end else begin
            holder = -1; run = 0;
         end
      end
   end

   // Every-cycle compare against the model plus structural invariants
   logic prev_rd0 = 1'b0, prev_rd1 = 1'b0;
   always @(negedge clk) begin
      chk("m0_gnt", m0_gnt, holder == 0);
      chk("m1_gnt", m1_gnt, holder == 1);
      chk("mem_cs", mem_cs, holder >= 0);
      chk("mem_w", mem_w, holder >= 0 && we_of(holder));
      chk("mem_r", mem_r, holder >= 0 && !we_of(holder));
      chk("mem_addr", mem_addr, (holder >= 0) ? addr_of(holder) : '0);
      chk("mem_wdata", mem_wdata, (holder >= 0) ? wdata_of(holder) : '0);
      chk("m0_rvalid", m0_rvalid, e_rv[0]);
      chk("m1_rvalid", m1_rvalid, e_rv[1]);
      chk("rdata", rdata, e_rdata);
      chk("one_gnt", m0_gnt && m1_gnt, 1'b0);
      chk("cs_eq_gnt", mem_cs, m0_gnt | m1_gnt);
      chk("rv0_after_rd", m0_rvalid && !prev_rd0, 1'b0);
      chk("rv1_after_rd", m1_rvalid && !prev_rd1, 1'b0);
      prev_rd0 = m0_gnt && !m0_we;
      prev_rd1 = m1_gnt && !m1_we;
   end

   // Master 0: present queue head, retire it once a grant was seen
   logic g0s; bit drv0; txn_t t0c;
   initial begin
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0; drv0 = 0;
      forever begin
         @(negedge clk); g0s = m0_gnt;
         @(posedge clk); #1;
         if (!rst_n) begin q0.delete(); drv0 = 0; end
         else if (g0s && drv0 && q0.size() > 0) t0c = q0.pop_front();
         if (rst_n && q0.size() > 0) begin
            m0_req = 1; m0_we = q0[0].we; m0_addr = q0[0].addr;
            m0_wdata = q0[0].wdata; m0_lock = q0[0].lock; drv0 = 1;
         end else begin
            m0_req = 0; m0_lock = 0; drv0 = 0;
         end
      end
   end

   // Master 1: same protocol
   logic g1s; bit drv1; txn_t t1c;
   initial begin
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0; drv1 = 0;
      forever begin
         @(negedge clk); g1s = m1_gnt;
         @(posedge clk); #1;
         if (!rst_n) begin q1.delete(); drv1 = 0; end
         else if (g1s && drv1 && q1.size() > 0) t1c = q1.pop_front();
         if (rst_n && q1.size() > 0) begin
            m1_req = 1; m1_we = q1[0].we; m1_addr = q1[0].addr;
            m1_wdata = q1[0].wdata; m1_lock = q1[0].lock; drv1 = 1;
         end else begin
            m1_req = 0; m1_lock = 0; drv1 = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      ticks(2);
      rst_n = 1'b1;
      tick();
   endtask

   function automatic txn_t mk(input logic we, input int addr, input logic [DW-1:0] wd, input logic lock);
      txn_t t;
      t.we = we; t.addr = AW'(addr); t.wdata = wd; t.lock = lock;
      return t;
   endfunction

   initial begin
      ticks(2);
      chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
      chk("rst_cs", mem_cs, 1'b0);
      chk("rst_rdata", rdata, '0);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      rst_n = 1'b1;
      tick();

      // Single read of addr 5
      q0.push_back(mk(1'b0, 5, '0, 1'b0));
      ticks(2);
      chk("rd_gnt", m0_gnt, 1'b1);
      chk("rd_addr", mem_addr, 10'd5);
      tick();
      chk("rd_rvalid", m0_rvalid, 1'b1);
      chk("rd_rdata", rdata, 32'hDEAD_BEEF);
      ticks(5);

      // Contention from reset
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(mk(1'b0, 1 + i, '0, 1'b0));
         q1.push_back(mk(1'b0, 16 + i, '0, 1'b0));
      end
      ticks(2);
      chk("rr_c1", {m0_gnt, m1_gnt}, 2'b10);
      tick();
      chk("rr_c2", {m0_gnt, m1_gnt}, 2'b01);
      tick();
      chk("rr_c3", {m0_gnt, m1_gnt}, 2'b10);
      tick();
      chk("rr_c4", {m0_gnt, m1_gnt}, 2'b01);
      ticks(6);

      // Locked burst of 8 writes from m1 against a pending m0 read
      for (int i = 0; i < 8; i++) q1.push_back(mk(1'b1, i, 32'hB000_0000 + i, 1'b1));
      tick();
      q0.push_back(mk(1'b0, 5, '0, 1'b0));
      tick();
      chk("bst_c1", {m0_gnt, m1_gnt}, 2'b01);
      tick();
      chk("bst_c2", {m0_gnt, m1_gnt}, 2'b01);
      tick();
      chk("bst_c3", {m0_gnt, m1_gnt}, 2'b01);
      tick();
      chk("bst_c4", {m0_gnt, m1_gnt}, 2'b01);
      chk("bst_c4_addr", mem_addr, 10'd3);
      tick();
      chk("bst_m0", {m0_gnt, m1_gnt}, 2'b10);
      tick();
      chk("bst_resume", {m0_gnt, m1_gnt}, 2'b01);
      chk("bst_resume_addr", mem_addr, 10'd4);
      ticks(8);

      // Write then read back at addr 9
      q1.push_back(mk(1'b1, 9, 32'h1234_5678, 1'b0));
      q1.push_back(mk(1'b0, 9, '0, 1'b0));
      ticks(2);
      chk("wr_gnt", {m1_gnt, mem_w}, 2'b11);
      chk("wr_wdata", mem_wdata, 32'h1234_5678);
      tick();
      chk("rb_gnt", {m1_gnt, mem_r}, 2'b11);
      tick();
      chk("rb_rvalid", m1_rvalid, 1'b1);
      chk("rb_rdata", rdata, 32'h1234_5678);
      ticks(5);

      // Reset during the second locked grant
      reset_dut();
      for (int i = 0; i < 4; i++) q1.push_back(mk(1'b1, 20 + i, 32'hC000_0000 + i, 1'b1));
      ticks(2);
      chk("rm_c1", m1_gnt, 1'b1);
      tick();
      chk("rm_c2", m1_gnt, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("rm_gnt", {m0_gnt, m1_gnt}, 2'b00);
      chk("rm_cs", mem_cs, 1'b0);
      chk("rm_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      ticks(2);
      rst_n = 1'b1;
      q0.push_back(mk(1'b0, 5, '0, 1'b0));
      q1.push_back(mk(1'b0, 6, '0, 1'b0));
      ticks(2);
      chk("rm_tie", {m0_gnt, m1_gnt}, 2'b10);
      ticks(6);

      // Mixed traffic, checked by the per-cycle model only
      for (int i = 0; i < 6; i++) begin
         q0.push_back(mk(i[0], 30 + i, 32'hD000_0000 + i, i[1]));
         q1.push_back(mk(~i[0], 30 + i, 32'hE000_0000 + i, 1'b1));
      end
      ticks(30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, meaning the word address width.
REQ-002 SHALL have parameter DW, default 32, meaning the data width.
REQ-003 SHALL have parameter BURST_MAX, default 4, meaning the maximum consecutive locked grants; legal range 1..16.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports m0_req / m1_req, input, 1, access request.
REQ-007 SHALL have ports m0_we / m1_we, input, 1, 1=write, 0=read.
REQ-008 SHALL have ports m0_lock / m1_lock, input, 1, request to keep the grant (burst).
REQ-009 SHALL have ports m0_addr / m1_addr, input, AW, word address.
REQ-010 SHALL have ports m0_wdata / m1_wdata, input, DW, write data.
REQ-011 SHALL have ports m0_gnt / m1_gnt, output, 1, access accepted this cycle.
REQ-012 SHALL have ports m0_rvalid / m1_rvalid, output, 1, one-cycle read-data strobe.
REQ-013 SHALL have port rdata, output, DW, registered read data, shared by both masters.
REQ-014 SHALL have ports mem_cs, mem_w, mem_r, output, 1 each, driving the memory CS / DM_W / DM_R.
REQ-015 SHALL have ports mem_addr (AW) and mem_wdata (DW), output, memory address and write data.
REQ-016 SHALL have port mem_rdata, input, DW, combinational memory read data.

Function
REQ-017 SHALL implement state IDLE/BUSY, owner (1 bit), last-granted pointer rr (1 bit) and burst counter cnt (4 bits).
REQ-018 In BUSY, mN_gnt SHALL equal (owner==N); both SHALL be 0 in IDLE, so at most one gnt is high.
REQ-019 In BUSY: mem_cs=1, mem_w=owner we, mem_r=!owner we, mem_addr/mem_wdata=owner addr/wdata, all combinational; in IDLE all memory outputs SHALL be 0.
REQ-020 A master SHALL hold req/we/addr/wdata/lock stable until it samples its gnt high at a posedge; each gnt-high cycle is exactly one word transfer.
REQ-021 Next-state at each posedge: keep owner with cnt+1 if BUSY and owner req && owner lock && cnt<BURST_MAX-1; else, if any req, grant the winner with cnt=0, state BUSY; else IDLE with cnt=0.
REQ-022 Winner selection: if only one req, that master; if both, the master != rr (round-robin).
REQ-023 rr SHALL update to the winner on every new grant (cnt reset to 0), not on burst continuation.
REQ-024 A read accepted in cycle T SHALL give rdata=mem_rdata captured at the end of T, with mN_rvalid=1 for exactly cycle T+1; rdata SHALL hold its value otherwise.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 Back-to-back accesses SHALL have no bubble: throughput is one access per cycle while any req is high.
REQ-027 If the owner drops lock or req mid-burst, re-arbitration SHALL occur at that posedge; at BURST_MAX the other master, if requesting, SHALL win.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, owner=0, rr=1 (m0 wins the first tie), cnt=0, rdata=0, rvalid=0.
REQ-029 Consequently gnt and mem_cs SHALL drop immediately on reset; an access in flight is abandoned, with no rvalid after reset release.

Structure
REQ-030 A shared package SHALL hold the IDLE/BUSY state encoding and the master-index constants M0=0, M1=1.
REQ-031 The round-robin winner selection SHALL be one sub-module, rr_pick2 (inputs req[1:0], rr; output winner, any).

Verification
REQ-032 Single read: m0 reads addr 5 (mem holds 0xDEADBEEF) -> m0_gnt in cycle 1, m0_rvalid=1 with rdata=0xDEADBEEF in cycle 2.
REQ-033 Contention: m0 and m1 req together from reset -> grants m0, m1, m0, m1 on consecutive cycles, no idle cycle.
REQ-034 Burst: m1 lock=1 for 8 writes to addrs 0..7, m0 requesting, BURST_MAX=4 -> m1 granted 4 cycles, then m0 once, then m1 resumes.
REQ-035 Write-then-read: m1 writes 0x12345678 to addr 9, then reads addr 9 -> rdata=0x12345678 with m1_rvalid the cycle after the read gnt.
REQ-036 Reset mid-burst: rst_n low during the 2nd locked grant -> gnt, mem_cs and rvalid go 0 the same cycle; after release, m0 wins the first tie.
REQ-037 Invariant checks across all scenarios: never m0_gnt&&m1_gnt; mem_cs==(m0_gnt|m1_gnt); rvalid only after a read gnt.
